// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing constants and the query-feeder state encoding.
package hdc_pkg;
  localparam int SEQ_CYCLE_COUNT = 10;
  localparam int NUM_CLASSES     = 26;
  localparam int CLASS_W         = $clog2(NUM_CLASSES);
  localparam int SEG_CTR_W       = 4;

  localparam logic [SEG_CTR_W-1:0] LAST_SEG = SEG_CTR_W'(SEQ_CYCLE_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_START,
    S_RUN,
    S_DONE
  } feeder_state_t;
endpackage

// File: rtl/hv_pingpong_buf.sv
// Two-bank query HV segment store with per-bank label and valid flag; one bank is
// read by the AM while the other is refilled from test memory.
module hv_pingpong_buf
  import hdc_pkg::*;
#(
  parameter int SEG_W = 1024
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [SEG_CTR_W-1:0] wr_seg,
  input  logic [SEG_W-1:0]     wr_data,
  input  logic                 label_wr_en,
  input  logic [CLASS_W-1:0]   label_data,
  input  logic                 rd_bank,
  input  logic [SEG_CTR_W-1:0] rd_seg,
  output logic [SEG_W-1:0]     rd_data,
  output logic [CLASS_W-1:0]   rd_label,
  input  logic                 set_valid,
  input  logic                 set_bank,
  input  logic                 clr_valid,
  input  logic                 clr_bank,
  input  logic                 clr_all,
  output logic [1:0]           valid
);
  logic [SEG_W-1:0]   seg_mem [2][SEQ_CYCLE_COUNT];
  logic [CLASS_W-1:0] label_mem [2];
  logic [1:0]         valid_reg;
  logic [1:0]         set_hit;
  logic [1:0]         clr_hit;

  always_ff @(posedge clk) begin
    if (wr_en) seg_mem[wr_bank][wr_seg] <= wr_data;
    if (label_wr_en) label_mem[wr_bank] <= label_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign set_hit[gi] = set_valid && (set_bank == 1'(gi));
      assign clr_hit[gi] = clr_valid && (clr_bank == 1'(gi));
    end
  endgenerate

  // A bank finishing its load wins over a same-cycle release of that bank.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) valid_reg <= 2'b00;
    else if (clr_all) valid_reg <= 2'b00;
    else valid_reg <= (valid_reg & ~clr_hit) | set_hit;
  end

  assign valid    = valid_reg;
  assign rd_data  = (rd_seg <= LAST_SEG) ? seg_mem[rd_bank][rd_seg] : '0;
  assign rd_label = label_mem[rd_bank];
endmodule

// File: rtl/am_query_feeder.sv
// Streams test-sample query HVs into a ping-pong buffer for the AM controller and
// counts correct predictions over one pass of the test set.
module am_query_feeder
  import hdc_pkg::*;
#(
  parameter int NUM_TEST_SAMPLES = 100,
  parameter int SEG_W            = 1024,
  parameter int ADDR_W           = $clog2(NUM_TEST_SAMPLES * SEQ_CYCLE_COUNT),
  parameter int SAMPLE_W         = $clog2(NUM_TEST_SAMPLES + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                start_test,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [SEG_W-1:0]    mem_rd_data,
  input  logic [CLASS_W-1:0]  label_rd_data,
  input  logic [3:0]          query_ctr,
  output logic [SEG_W-1:0]    query_seg,
  output logic                start_querying,
  output logic                testing_dataset_finished,
  input  logic                tallying_accuracy,
  input  logic [CLASS_W-1:0]  predicted_class,
  output logic [SAMPLE_W-1:0] correct_ctr,
  output logic                test_done,
  output logic                overrun_err
);
  localparam logic [SAMPLE_W-1:0] LAST_IDX = SAMPLE_W'(NUM_TEST_SAMPLES - 1);
  localparam bit MULTI = (NUM_TEST_SAMPLES > 1);

  feeder_state_t state_reg, state_next;

  logic                 active_buf_reg;
  logic [SAMPLE_W-1:0]  query_idx_reg;
  logic [SAMPLE_W-1:0]  correct_ctr_reg;
  logic                 overrun_reg;

  logic                 issuing_reg;
  logic [SEG_CTR_W-1:0] load_seg_reg;
  logic [SAMPLE_W-1:0]  load_sample_reg;
  logic                 load_bank_reg;
  logic                 ret_valid_reg;
  logic [SEG_CTR_W-1:0] ret_seg_reg;
  logic                 ret_bank_reg;

  logic                 start_pass;
  logic                 run_entry;
  logic                 tally;
  logic                 last_query;
  logic                 load_last;
  logic                 bg_start;
  logic [ADDR_W-1:0]    addr_calc;
  logic [SEG_W-1:0]     buf_seg;
  logic [CLASS_W-1:0]   buf_label;
  logic [1:0]           buf_valid;

  assign start_pass = (state_reg == S_IDLE) && start_test && en;
  assign run_entry  = (state_reg == S_START) && en;
  assign tally      = (state_reg == S_RUN) && tallying_accuracy;
  assign last_query = (query_idx_reg == LAST_IDX);
  assign load_last  = ret_valid_reg && (ret_seg_reg == LAST_SEG);
  // load_sample_reg always holds the most recently started sample, so loads are in order.
  assign bg_start   = (run_entry && MULTI) ||
                      (tally && !last_query && (load_sample_reg != LAST_IDX));
  assign addr_calc  = ADDR_W'(load_sample_reg) * ADDR_W'(SEQ_CYCLE_COUNT) +
                      ADDR_W'(load_seg_reg);

  hv_pingpong_buf #(
    .SEG_W(SEG_W)
  ) u_buf (
    .clk        (clk),
    .nrst       (nrst),
    .wr_en      (ret_valid_reg),
    .wr_bank    (ret_bank_reg),
    .wr_seg     (ret_seg_reg),
    .wr_data    (mem_rd_data),
    .label_wr_en(ret_valid_reg && (ret_seg_reg == '0)),
    .label_data (label_rd_data),
    .rd_bank    (active_buf_reg),
    .rd_seg     (query_ctr),
    .rd_data    (buf_seg),
    .rd_label   (buf_label),
    .set_valid  (load_last),
    .set_bank   (ret_bank_reg),
    .clr_valid  (tally),
    .clr_bank   (active_buf_reg),
    .clr_all    (start_pass),
    .valid      (buf_valid)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_reg <= S_IDLE;
    else state_reg <= state_next;
  end

  always_comb begin
    state_next               = state_reg;
    start_querying           = 1'b0;
    testing_dataset_finished = 1'b0;
    test_done                = 1'b0;
    case (state_reg)
      S_IDLE:    if (start_pass) state_next = S_PRELOAD;
      S_PRELOAD: if (load_last) state_next = S_START;
      S_START: begin
        start_querying = 1'b1;
        if (en) state_next = S_RUN;
      end
      S_RUN: begin
        testing_dataset_finished = last_query;
        if (tallying_accuracy && last_query) state_next = S_DONE;
      end
      S_DONE: begin
        test_done  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Loader: issue phase plus a one-deep return pipeline matching the memory latency.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      issuing_reg     <= 1'b0;
      load_seg_reg    <= '0;
      load_sample_reg <= '0;
      load_bank_reg   <= 1'b0;
      ret_valid_reg   <= 1'b0;
      ret_seg_reg     <= '0;
      ret_bank_reg    <= 1'b0;
    end else begin
      ret_valid_reg <= issuing_reg && !start_pass;
      ret_seg_reg   <= load_seg_reg;
      ret_bank_reg  <= load_bank_reg;
      if (start_pass) begin
        issuing_reg     <= 1'b1;
        load_seg_reg    <= '0;
        load_sample_reg <= '0;
        load_bank_reg   <= 1'b0;
      end else if (bg_start) begin
        issuing_reg     <= 1'b1;
        load_seg_reg    <= '0;
        load_sample_reg <= load_sample_reg + 1'b1;
        load_bank_reg   <= run_entry ? 1'b1 : active_buf_reg;
      end else if (issuing_reg) begin
        load_seg_reg <= load_seg_reg + 1'b1;
        if (load_seg_reg == LAST_SEG) issuing_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active_buf_reg  <= 1'b0;
      query_idx_reg   <= '0;
      correct_ctr_reg <= '0;
      overrun_reg     <= 1'b0;
    end else if (start_pass) begin
      active_buf_reg  <= 1'b0;
      query_idx_reg   <= '0;
      correct_ctr_reg <= '0;
      overrun_reg     <= 1'b0;
    end else if (tally) begin
      if (predicted_class == buf_label) correct_ctr_reg <= correct_ctr_reg + 1'b1;
      active_buf_reg <= ~active_buf_reg;
      query_idx_reg  <= query_idx_reg + 1'b1;
      // After the final sample there is nothing left to be ready.
      if (!last_query && !buf_valid[~active_buf_reg]) overrun_reg <= 1'b1;
    end
  end

  assign mem_rd_en   = issuing_reg;
  assign mem_rd_addr = issuing_reg ? addr_calc : '0;
  assign query_seg   = ((state_reg == S_START) || (state_reg == S_RUN)) ? buf_seg : '0;
  assign correct_ctr = correct_ctr_reg;
  assign overrun_err = overrun_reg;
endmodule

// File: tb/tb_am_query_feeder.sv
// Directed bench for am_query_feeder: a 3-sample instance (normal, en-stall, overrun,
// mid-pass reset) and a 1-sample instance, with an address scoreboard per instance.
module tb_am_query_feeder;
  import hdc_pkg::*;

  localparam int SW  = 16;
  localparam int AWA = $clog2(3 * SEQ_CYCLE_COUNT);
  localparam int CWA = $clog2(4);
  localparam int AWB = $clog2(SEQ_CYCLE_COUNT);
  localparam int CWB = $clog2(2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]         qctr  = '0;
  logic               tally = 1'b0;
  logic [CLASS_W-1:0] pred  = '0;

  logic nrst_a = 1'b0, en_a = 1'b0, start_a = 1'b0;
  logic rd_en_a, qf_a, tdf_a, done_a, ovr_a;
  logic [AWA-1:0] addr_a;
  logic [SW-1:0] rdata_a = '0;
  logic [SW-1:0] qseg_a;
  logic [CLASS_W-1:0] lbl_a = '0;
  logic [CWA-1:0] corr_a;

  logic nrst_b = 1'b0, en_b = 1'b0, start_b = 1'b0;
  logic rd_en_b, qf_b, tdf_b, done_b, ovr_b;
  logic [AWB-1:0] addr_b;
  logic [SW-1:0] rdata_b = '0;
  logic [SW-1:0] qseg_b;
  logic [CLASS_W-1:0] lbl_b = '0;
  logic [CWB-1:0] corr_b;

  am_query_feeder #(.NUM_TEST_SAMPLES(3), .SEG_W(SW)) dut_a (
    .clk(clk), .nrst(nrst_a), .en(en_a), .start_test(start_a),
    .mem_rd_en(rd_en_a), .mem_rd_addr(addr_a), .mem_rd_data(rdata_a),
    .label_rd_data(lbl_a), .query_ctr(qctr), .query_seg(qseg_a),
    .start_querying(qf_a), .testing_dataset_finished(tdf_a),
    .tallying_accuracy(tally), .predicted_class(pred), .correct_ctr(corr_a),
    .test_done(done_a), .overrun_err(ovr_a)
  );

  am_query_feeder #(.NUM_TEST_SAMPLES(1), .SEG_W(SW)) dut_b (
    .clk(clk), .nrst(nrst_b), .en(en_b), .start_test(start_b),
    .mem_rd_en(rd_en_b), .mem_rd_addr(addr_b), .mem_rd_data(rdata_b),
    .label_rd_data(lbl_b), .query_ctr(qctr), .query_seg(qseg_b),
    .start_querying(qf_b), .testing_dataset_finished(tdf_b),
    .tallying_accuracy(tally), .predicted_class(pred), .correct_ctr(corr_b),
    .test_done(done_b), .overrun_err(ovr_b)
  );

  // Test memory: word = address; labels 3, 7, 9 for samples 0, 1, 2.
  function automatic logic [CLASS_W-1:0] label_of(input int a);
    if (a < SEQ_CYCLE_COUNT) return CLASS_W'(3);
    else if (a < 2 * SEQ_CYCLE_COUNT) return CLASS_W'(7);
    else return CLASS_W'(9);
  endfunction

  always @(posedge clk) begin
    if (rd_en_a) begin
      rdata_a <= SW'(addr_a);
      lbl_a   <= label_of(int'(addr_a));
    end
    if (rd_en_b) begin
      rdata_b <= SW'(addr_b);
      lbl_b   <= label_of(int'(addr_b));
    end
  end

  int checks = 0;
  int errors = 0;
  int addr_qa[$];
  int addr_qb[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; every memory read is popped against the expected address stream.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (rd_en_a) begin
      e = -1;
      if (addr_qa.size() != 0) e = addr_qa.pop_front();
      chk("mem_rd_addr_a", 32'(addr_a), e);
    end
    if (rd_en_b) begin
      e = -1;
      if (addr_qb.size() != 0) e = addr_qb.pop_front();
      chk("mem_rd_addr_b", 32'(addr_b), e);
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  endtask

  task automatic push_addrs(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (b) addr_qb.push_back(i);
      else addr_qa.push_back(i);
    end
  endtask

  task automatic wait_qf(input bit b, output int n);
    n = 1;
    while (!(b ? qf_b : qf_a) && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Behavioural AM: 10 query cycles, one out-of-range cycle, then the tally cycle.
  task automatic am_sample(input bit b, input int s, input logic [CLASS_W-1:0] p, input bit last);
    for (int g = 0; g < SEQ_CYCLE_COUNT; g++) begin
      qctr = 4'(g);
      #1;
      chk("query_seg", 32'(b ? qseg_b : qseg_a), 32'(s * SEQ_CYCLE_COUNT + g));
      chk("dataset_finished", 32'(b ? tdf_b : tdf_a), 32'(last));
      tick();
    end
    qctr = 4'd10;
    #1;
    chk("query_seg_oor", 32'(b ? qseg_b : qseg_a), 0);
    tick();
    tally = 1'b1;
    pred  = p;
    #1;
    chk("dataset_finished_tally", 32'(b ? tdf_b : tdf_a), 32'(last));
    tick();
    tally = 1'b0;
    qctr  = '0;
  endtask

  task automatic tally_after(input int idle, input logic [CLASS_W-1:0] p);
    repeat (idle) tick();
    tally = 1'b1;
    pred  = p;
    tick();
    tally = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk("reset_outputs_a", {rd_en_a, qf_a, tdf_a, done_a, ovr_a, corr_a, addr_a, qseg_a}, 0);
    chk("reset_outputs_b", {rd_en_b, qf_b, tdf_b, done_b, ovr_b, corr_b, addr_b, qseg_b}, 0);
    nrst_a = 1'b1;
    nrst_b = 1'b1;
    tick();

    // Pass 1: healthy run, en dropped during preload and held low in S_START.
    push_addrs(1'b0, 3 * SEQ_CYCLE_COUNT);
    start_a = 1'b1;
    en_a    = 1'b1;
    tick();
    start_a = 1'b0;
    en_a    = 1'b0;
    wait_qf(1'b0, n);
    chk("start_querying_latency", n, 12);
    chk("preload_reads_left", addr_qa.size(), 2 * SEQ_CYCLE_COUNT);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("start_querying_hold", 32'(qf_a), 1);
    end
    en_a = 1'b1;
    tick();
    chk("start_querying_exit", 32'(qf_a), 0);
    am_sample(1'b0, 0, CLASS_W'(3), 1'b0);
    am_sample(1'b0, 1, CLASS_W'(7), 1'b0);
    am_sample(1'b0, 2, CLASS_W'(1), 1'b1);
    chk("test_done_pulse", 32'(done_a), 1);
    tick();
    tick();
    chk("test_done_count", done_cnt_a, 1);
    chk("correct_ctr", 32'(corr_a), 2);
    chk("overrun_healthy", 32'(ovr_a), 0);
    chk("reads_consumed", addr_qa.size(), 0);
    chk("dataset_finished_idle", 32'(tdf_a), 0);

    // Pass 2: second tally only 4 cycles after the first.
    done_cnt_a = 0;
    push_addrs(1'b0, 3 * SEQ_CYCLE_COUNT);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("correct_ctr_cleared", 32'(corr_a), 0);
    wait_qf(1'b0, n);
    chk("start_querying_latency2", n, 12);
    tick();
    tally_after(11, CLASS_W'(3));
    chk("overrun_first_tally", 32'(ovr_a), 0);
    tally_after(3, CLASS_W'(7));
    chk("overrun_short_query", 32'(ovr_a), 1);
    tally_after(10, CLASS_W'(9));
    chk("test_done_pulse2", 32'(done_a), 1);
    tick();
    tick();
    chk("overrun_sticky", 32'(ovr_a), 1);
    chk("test_done_count2", done_cnt_a, 1);
    chk("reads_consumed2", addr_qa.size(), 0);

    // Pass 3: reset in the middle of sample 1, then restart.
    push_addrs(1'b0, 3 * SEQ_CYCLE_COUNT);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("overrun_cleared", 32'(ovr_a), 0);
    wait_qf(1'b0, n);
    tick();
    am_sample(1'b0, 0, CLASS_W'(3), 1'b0);
    repeat (3) tick();
    nrst_a = 1'b0;
    #1;
    chk("midpass_reset_outputs", {rd_en_a, qf_a, tdf_a, done_a, ovr_a, corr_a, addr_a, qseg_a}, 0);
    tick();
    chk("midpass_reset_held", {rd_en_a, qf_a, tdf_a, done_a, ovr_a, corr_a, addr_a, qseg_a}, 0);
    addr_qa.delete();
    nrst_a = 1'b1;
    tick();
    push_addrs(1'b0, SEQ_CYCLE_COUNT);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    en_a    = 1'b0;
    chk("restart_correct_ctr", 32'(corr_a), 0);
    wait_qf(1'b0, n);
    chk("restart_latency", n, 12);
    chk("restart_reads", addr_qa.size(), 0);

    // Single-sample instance.
    push_addrs(1'b1, SEQ_CYCLE_COUNT);
    start_b = 1'b1;
    en_b    = 1'b1;
    tick();
    start_b = 1'b0;
    wait_qf(1'b1, n);
    chk("start_querying_latency_b", n, 12);
    tick();
    chk("dataset_finished_entry_b", 32'(tdf_b), 1);
    am_sample(1'b1, 0, CLASS_W'(3), 1'b1);
    chk("test_done_pulse_b", 32'(done_b), 1);
    repeat (15) tick();
    chk("test_done_count_b", done_cnt_b, 1);
    chk("correct_ctr_b", 32'(corr_b), 1);
    chk("overrun_b", 32'(ovr_b), 0);
    chk("reads_consumed_b", addr_qb.size(), 0);
    chk("a_parked_in_start", 32'(qf_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
